cpu6_trap_ctrl: RTL and testbench
=================================

Name: cpu6_trap_ctrl

Overview:
Trap sequencer for the cpu6 core, sitting between the commit-stage exception sources and the CSR file / fetch redirect.
- Prioritises synchronous exceptions and enabled machine interrupts, and stalls the pipeline until it has drained.
- Then pulses the CSR update strobes (mepc/mcause/mtval/mstatus) and redirects fetch to the mtvec target.
- Also sequences mret: restores mstatus and redirects fetch to mepc.

Parameters:
XLEN, `CPU6_XLEN (32), datapath width.
VECTORED_EN, 1, honour mtvec MODE=01 for interrupts (target = BASE + 4*cause); 0 means always direct.

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-high reset
excp_valid  in  1  valid instruction at commit (qualifies all event inputs)
excp_pc  in  XLEN  PC of committing instruction
excp_instr  in  XLEN  instruction word (mtval for illegal)
excp_badaddr  in  XLEN  faulting data address (mtval for misaligned)
excp_illinstr  in  1  illegal instruction
excp_ebreak  in  1  ebreak
excp_ecall  in  1  ecall
excp_st_misalign  in  1  store address misaligned
excp_ld_misalign  in  1  load address misaligned
excp_mret  in  1  mret at commit
irq_pend  in  3  {MEIP,MTIP,MSIP} raw pending
csr_mie  in  3  {MEIE,MTIE,MSIE}
csr_mstatus_mie  in  1  global interrupt enable
csr_mtvec  in  XLEN  trap vector
csr_mepc  in  XLEN  return PC
pipe_drained  in  1  all older in-flight ops retired/killed
trap_stall  out  1  hold fetch/commit
excp_flush_pc_ena  out  1  one-cycle redirect strobe
excp_flush_pc  out  XLEN  redirect target
excp_mepc / excp_mepc_ena  out  XLEN / 1  mepc write
excp_mcause / excp_mcause_ena  out  XLEN / 1  mcause write
excp_mtval / excp_mtval_ena  out  XLEN / 1  mtval write
excp_mstatus_trap  out  1  pulse: MPIE<=MIE, MIE<=0
excp_mstatus_mret  out  1  pulse: MIE<=MPIE, MPIE<=1

Behaviour:
- Reset (async): state=IDLE; every output and every capture register is 0. Reset mid-sequence aborts with no strobes.
- Enabled interrupt: ien = irq_pend & csr_mie & {3{csr_mstatus_mie}}.
- Accept condition: in IDLE with excp_valid=1 and (ien!=0, any exception, or excp_mret).
- Priority on accept, highest first:
  - Interrupts: MEI (cause 11), MSI (3), MTI (7). Interrupt causes set mcause[XLEN-1]=1.
  - Exceptions: illinstr (2), ebreak (3), ecall (11), st_misalign (6), ld_misalign (4).
  - mret: lowest; ignored if any trap is taken the same cycle.
- Captured on accept (cycle 0):
  - mepc = excp_pc; the trapping instruction does not retire.
  - cause.
  - mtval: illegal=excp_instr; misaligned=excp_badaddr; ebreak=excp_pc; else 0.
  - target:
    - Trap: csr_mtvec[XLEN-1:2]<<2, plus 4*cause if VECTORED_EN, interrupt and mtvec[1:0]==01.
    - mret: csr_mepc.
- trap_stall is combinationally high in cycle 0 on accept, and high in every non-IDLE state.
- FSM:
  - IDLE -> DRAIN on accept.
  - DRAIN: wait for pipe_drained=1 (may already be high on entry). Then go to COMMIT (trap) or MRET (mret).
  - COMMIT (1 cycle): excp_mepc_ena=excp_mcause_ena=excp_mtval_ena=excp_mstatus_trap=1, with captured values -> REDIRECT.
  - REDIRECT (1 cycle): excp_flush_pc_ena=1, excp_flush_pc=target -> IDLE.
  - MRET (1 cycle): excp_mstatus_mret=1, excp_flush_pc_ena=1, excp_flush_pc=target -> IDLE.
- Latency with pipe_drained high:
  - Trap: accept at cycle 0, CSR strobes at cycle 2, redirect at cycle 3, IDLE at cycle 4.
  - mret: redirect at cycle 2.
- The redirect is issued one cycle after the CSR writes, so CSR values are architecturally visible before the first handler fetch.
- Event inputs in non-IDLE states are ignored. The pipeline must re-present any unhandled event after the redirect.
- Interrupt deasserting after accept: no effect, the sequence completes.
- Strobe outputs are registered, never combinational from inputs. Data outputs hold their captured values until the next accept.

Decomposition:
- Constants in defines.v:
  - cause codes (CPU6_CAUSE_*);
  - FSM state encoding (3-bit: IDLE, DRAIN, COMMIT, REDIRECT, MRET);
  - irq bit positions.
- One sub-module: cpu6_trap_prio, a combinational priority encoder that takes the event vector plus ien and returns take, is_int, cause[4:0] and the mtval select.

Test Plan:
- excp_illinstr, excp_pc=0x100, excp_instr=0xFFFFFFFF, mtvec=0x800, pipe_drained=1 -> cycle 2: mepc=0x100, mcause=2, mtval=0xFFFFFFFF, mstatus_trap=1; cycle 3: flush_pc=0x800, flush_pc_ena=1; trap_stall high for cycles 0-3.
- MTIP+MTIE, mstatus_mie=1, mtvec=0x801, VECTORED_EN=1 -> mcause=0x80000007, flush_pc=0x81C; with mstatus_mie=0 -> no accept, trap_stall=0.
- MEIP+MTIP pending together with excp_ecall -> mcause=0x8000000B, mepc=excp_pc, mtval=0.
- excp_mret, csr_mepc=0x2000, pipe_drained low for 5 cycles -> stays in DRAIN; one cycle after drain: mstatus_mret=1, flush_pc=0x2000; mret plus simultaneous ld_misalign -> trap taken with mcause=4, no mstatus_mret.
- Reset asserted in DRAIN, then released -> all outputs 0 and IDLE; a new ebreak at pc=0x40 -> mtval=0x40, mcause=3.

Source files
------------

// File: rtl/cpu6_trap_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu6_trap_ctrl_pkg                                                   |
// | Shared constants for the cpu6 trap sequencer: cause codes, irq bit   |
// | positions, FSM state encoding and mtval source select.               |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
package cpu6_trap_ctrl_pkg;

  localparam int CPU6_XLEN = 32;

  // Interrupt cause codes (mcause[XLEN-1] is set separately)
  localparam logic [4:0] CPU6_CAUSE_MSI         = 5'd3;
  localparam logic [4:0] CPU6_CAUSE_MTI         = 5'd7;
  localparam logic [4:0] CPU6_CAUSE_MEI         = 5'd11;

  // Exception cause codes
  localparam logic [4:0] CPU6_CAUSE_ILLINSTR    = 5'd2;
  localparam logic [4:0] CPU6_CAUSE_EBREAK      = 5'd3;
  localparam logic [4:0] CPU6_CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CPU6_CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CPU6_CAUSE_ECALL       = 5'd11;

  // Bit positions inside irq_pend / csr_mie ({MEI,MTI,MSI})
  localparam int CPU6_IRQ_MSI = 0;
  localparam int CPU6_IRQ_MTI = 1;
  localparam int CPU6_IRQ_MEI = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_DRAIN    = 3'd1,
    ST_COMMIT   = 3'd2,
    ST_REDIRECT = 3'd3,
    ST_MRET     = 3'd4
  } trap_state_e;

  typedef enum logic [1:0] {
    MTVAL_ZERO    = 2'd0,
    MTVAL_INSTR   = 2'd1,
    MTVAL_BADADDR = 2'd2,
    MTVAL_PC      = 2'd3
  } mtval_sel_e;

endpackage
`default_nettype wire

// File: rtl/cpu6_trap_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu6_trap_prio                                                       |
// | Combinational priority encoder: picks the highest-priority enabled   |
// | interrupt or synchronous exception and reports cause/mtval source.  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module cpu6_trap_prio
  import cpu6_trap_ctrl_pkg::*;
(
  input  logic       illinstr,
  input  logic       ebreak,
  input  logic       ecall,
  input  logic       st_misalign,
  input  logic       ld_misalign,
  input  logic [2:0] ien,
  output logic       take,
  output logic       is_int,
  output logic [4:0] cause,
  output mtval_sel_e mtval_sel
);

  // Fixed priority: MEI > MSI > MTI > illegal > ebreak > ecall > st > ld
  always_comb begin
    take      = 1'b0;
    is_int    = 1'b0;
    cause     = 5'd0;
    mtval_sel = MTVAL_ZERO;
    if (ien[CPU6_IRQ_MEI]) begin
      take   = 1'b1;
      is_int = 1'b1;
      cause  = CPU6_CAUSE_MEI;
    end else if (ien[CPU6_IRQ_MSI]) begin
      take   = 1'b1;
      is_int = 1'b1;
      cause  = CPU6_CAUSE_MSI;
    end else if (ien[CPU6_IRQ_MTI]) begin
      take   = 1'b1;
      is_int = 1'b1;
      cause  = CPU6_CAUSE_MTI;
    end else if (illinstr) begin
      take      = 1'b1;
      cause     = CPU6_CAUSE_ILLINSTR;
      mtval_sel = MTVAL_INSTR;
    end else if (ebreak) begin
      take      = 1'b1;
      cause     = CPU6_CAUSE_EBREAK;
      mtval_sel = MTVAL_PC;
    end else if (ecall) begin
      take      = 1'b1;
      cause     = CPU6_CAUSE_ECALL;
    end else if (st_misalign) begin
      take      = 1'b1;
      cause     = CPU6_CAUSE_ST_MISALIGN;
      mtval_sel = MTVAL_BADADDR;
    end else if (ld_misalign) begin
      take      = 1'b1;
      cause     = CPU6_CAUSE_LD_MISALIGN;
      mtval_sel = MTVAL_BADADDR;
    end
  end

endmodule
`default_nettype wire

// File: rtl/cpu6_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cpu6_trap_ctrl                                                       |
// | Trap/mret sequencer: accepts commit-stage events, stalls until the   |
// | pipeline drains, strobes CSR updates, then redirects fetch.          |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int XLEN        = CPU6_XLEN,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            excp_valid,
  input  logic [XLEN-1:0] excp_pc,
  input  logic [XLEN-1:0] excp_instr,
  input  logic [XLEN-1:0] excp_badaddr,
  input  logic            excp_illinstr,
  input  logic            excp_ebreak,
  input  logic            excp_ecall,
  input  logic            excp_st_misalign,
  input  logic            excp_ld_misalign,
  input  logic            excp_mret,
  input  logic [2:0]      irq_pend,
  input  logic [2:0]      csr_mie,
  input  logic            csr_mstatus_mie,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic            pipe_drained,
  output logic            trap_stall,
  output logic            excp_flush_pc_ena,
  output logic [XLEN-1:0] excp_flush_pc,
  output logic [XLEN-1:0] excp_mepc,
  output logic            excp_mepc_ena,
  output logic [XLEN-1:0] excp_mcause,
  output logic            excp_mcause_ena,
  output logic [XLEN-1:0] excp_mtval,
  output logic            excp_mtval_ena,
  output logic            excp_mstatus_trap,
  output logic            excp_mstatus_mret
);

  trap_state_e     state_q, state_d;
  logic [2:0]      ien;
  logic            take;
  logic            is_int;
  logic [4:0]      cause;
  mtval_sel_e      mtval_sel;
  logic            accept;
  logic            accept_trap;
  logic [XLEN-1:0] cause_full;
  logic [XLEN-1:0] mtval_val;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] trap_target;

  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;
  logic [XLEN-1:0] target_q;
  logic            is_mret_q;
  logic            commit_q;
  logic            redirect_q;
  logic            mret_q;

  assign ien = irq_pend & csr_mie & {3{csr_mstatus_mie}};

  cpu6_trap_prio u_prio (
    .illinstr    (excp_illinstr),
    .ebreak      (excp_ebreak),
    .ecall       (excp_ecall),
    .st_misalign (excp_st_misalign),
    .ld_misalign (excp_ld_misalign),
    .ien         (ien),
    .take        (take),
    .is_int      (is_int),
    .cause       (cause),
    .mtval_sel   (mtval_sel)
  );

  // A trap always wins over an mret committing in the same cycle
  assign accept      = (state_q == ST_IDLE) && excp_valid && (take || excp_mret);
  assign accept_trap = accept && take;

  assign cause_full = {is_int, {(XLEN-6){1'b0}}, cause};
  assign trap_base  = {csr_mtvec[XLEN-1:2], 2'b00};

  // Vectored mode only offsets interrupts; exceptions always land on BASE
  always_comb begin
    trap_target = trap_base;
    if (VECTORED_EN && is_int && (csr_mtvec[1:0] == 2'b01)) begin
      trap_target = trap_base + {{(XLEN-7){1'b0}}, cause, 2'b00};
    end
  end

  // Select the mtval payload for the winning exception
  always_comb begin
    mtval_val = '0;
    case (mtval_sel)
      MTVAL_INSTR:   mtval_val = excp_instr;
      MTVAL_BADADDR: mtval_val = excp_badaddr;
      MTVAL_PC:      mtval_val = excp_pc;
      default:       mtval_val = '0;
    endcase
  end

  // Next-state logic for the trap/mret sequence
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pipe_drained) state_d = is_mret_q ? ST_MRET : ST_COMMIT;
      end
      ST_COMMIT:   state_d = ST_REDIRECT;
      ST_REDIRECT: state_d = ST_IDLE;
      ST_MRET:     state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // State register plus strobes registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      commit_q   <= 1'b0;
      redirect_q <= 1'b0;
      mret_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      commit_q   <= (state_d == ST_COMMIT);
      redirect_q <= (state_d == ST_REDIRECT) || (state_d == ST_MRET);
      mret_q     <= (state_d == ST_MRET);
    end
  end

  // Capture trap context on accept; mret only needs its return target
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
      target_q  <= '0;
      is_mret_q <= 1'b0;
    end else if (accept) begin
      is_mret_q <= !take;
      if (accept_trap) begin
        mepc_q   <= excp_pc;
        mcause_q <= cause_full;
        mtval_q  <= mtval_val;
        target_q <= trap_target;
      end else begin
        target_q <= csr_mepc;
      end
    end
  end

  assign trap_stall        = (state_q != ST_IDLE) || accept;
  assign excp_flush_pc_ena = redirect_q;
  assign excp_flush_pc     = target_q;
  assign excp_mepc         = mepc_q;
  assign excp_mepc_ena     = commit_q;
  assign excp_mcause       = mcause_q;
  assign excp_mcause_ena   = commit_q;
  assign excp_mtval        = mtval_q;
  assign excp_mtval_ena    = commit_q;
  assign excp_mstatus_trap = commit_q;
  assign excp_mstatus_mret = mret_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu6_trap_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cpu6_trap_ctrl                                                    |
// | Directed self-checking bench for the cpu6 trap sequencer.            |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_cpu6_trap_ctrl;

  localparam int XLEN = 32;

  logic            clk;
  logic            reset;
  logic            excp_valid;
  logic [XLEN-1:0] excp_pc, excp_instr, excp_badaddr;
  logic            excp_illinstr, excp_ebreak, excp_ecall;
  logic            excp_st_misalign, excp_ld_misalign, excp_mret;
  logic [2:0]      irq_pend, csr_mie;
  logic            csr_mstatus_mie;
  logic [XLEN-1:0] csr_mtvec, csr_mepc;
  logic            pipe_drained;
  logic            trap_stall, excp_flush_pc_ena;
  logic [XLEN-1:0] excp_flush_pc, excp_mepc, excp_mcause, excp_mtval;
  logic            excp_mepc_ena, excp_mcause_ena, excp_mtval_ena;
  logic            excp_mstatus_trap, excp_mstatus_mret;

  int checks;
  int failures;

  cpu6_trap_ctrl #(.XLEN(XLEN), .VECTORED_EN(1'b1)) dut (
    .clk               (clk),
    .reset             (reset),
    .excp_valid        (excp_valid),
    .excp_pc           (excp_pc),
    .excp_instr        (excp_instr),
    .excp_badaddr      (excp_badaddr),
    .excp_illinstr     (excp_illinstr),
    .excp_ebreak       (excp_ebreak),
    .excp_ecall        (excp_ecall),
    .excp_st_misalign  (excp_st_misalign),
    .excp_ld_misalign  (excp_ld_misalign),
    .excp_mret         (excp_mret),
    .irq_pend          (irq_pend),
    .csr_mie           (csr_mie),
    .csr_mstatus_mie   (csr_mstatus_mie),
    .csr_mtvec         (csr_mtvec),
    .csr_mepc          (csr_mepc),
    .pipe_drained      (pipe_drained),
    .trap_stall        (trap_stall),
    .excp_flush_pc_ena (excp_flush_pc_ena),
    .excp_flush_pc     (excp_flush_pc),
    .excp_mepc         (excp_mepc),
    .excp_mepc_ena     (excp_mepc_ena),
    .excp_mcause       (excp_mcause),
    .excp_mcause_ena   (excp_mcause_ena),
    .excp_mtval        (excp_mtval),
    .excp_mtval_ena    (excp_mtval_ena),
    .excp_mstatus_trap (excp_mstatus_trap),
    .excp_mstatus_mret (excp_mstatus_mret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_events();
    excp_valid       = 1'b0;
    excp_illinstr    = 1'b0;
    excp_ebreak      = 1'b0;
    excp_ecall       = 1'b0;
    excp_st_misalign = 1'b0;
    excp_ld_misalign = 1'b0;
    excp_mret        = 1'b0;
    irq_pend         = 3'b000;
  endtask

  // Present the already-set event for one cycle (cycle 0), checking the
  // combinational stall, then withdraw it just after the clock edge.
  task automatic fire(input string tag, input logic exp_stall);
    excp_valid = 1'b1;
    #1;
    check({tag, "_c0_stall"}, {31'd0, trap_stall}, {31'd0, exp_stall});
    @(posedge clk);
    #1;
    clear_events();
  endtask

  // Checks all CSR/redirect strobes in one go: {mepc,mcause,mtval,trap,mret,flush}
  task automatic check_strobes(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, excp_mepc_ena, excp_mcause_ena, excp_mtval_ena,
                excp_mstatus_trap, excp_mstatus_mret, excp_flush_pc_ena},
          {26'd0, exp});
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    clear_events();
    excp_pc         = '0;
    excp_instr      = '0;
    excp_badaddr    = '0;
    csr_mie         = 3'b000;
    csr_mstatus_mie = 1'b0;
    csr_mtvec       = 32'h0000_0800;
    csr_mepc        = '0;
    pipe_drained    = 1'b1;
    reset           = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_stall", {31'd0, trap_stall}, 32'd0);
    check_strobes("rst_strobes", 6'b000000);
    check("rst_flush_pc", excp_flush_pc, 32'd0);
    check("rst_mepc", excp_mepc, 32'd0);
    check("rst_mcause", excp_mcause, 32'd0);
    check("rst_mtval", excp_mtval, 32'd0);

    // ---------------- illegal instruction ----------------
    excp_pc = 32'h100; excp_instr = 32'hFFFF_FFFF; excp_illinstr = 1'b1;
    csr_mtvec = 32'h800;
    fire("ill", 1'b1);
    @(negedge clk);
    check("ill_c1_stall", {31'd0, trap_stall}, 32'd1);
    check_strobes("ill_c1_strobes", 6'b000000);
    @(negedge clk);
    check("ill_c2_stall", {31'd0, trap_stall}, 32'd1);
    check_strobes("ill_c2_strobes", 6'b111100);
    check("ill_mepc", excp_mepc, 32'h100);
    check("ill_mcause", excp_mcause, 32'd2);
    check("ill_mtval", excp_mtval, 32'hFFFF_FFFF);
    @(negedge clk);
    check("ill_c3_stall", {31'd0, trap_stall}, 32'd1);
    check_strobes("ill_c3_strobes", 6'b000001);
    check("ill_flush_pc", excp_flush_pc, 32'h800);
    @(negedge clk);
    check("ill_c4_stall", {31'd0, trap_stall}, 32'd0);
    check_strobes("ill_c4_strobes", 6'b000000);

    // ---------------- vectored timer interrupt ----------------
    excp_pc = 32'h204; csr_mtvec = 32'h801; csr_mie = 3'b010;
    csr_mstatus_mie = 1'b1; irq_pend = 3'b010;
    fire("mti", 1'b1);
    repeat (2) @(negedge clk);
    check_strobes("mti_c2_strobes", 6'b111100);
    check("mti_mcause", excp_mcause, 32'h8000_0007);
    check("mti_mepc", excp_mepc, 32'h204);
    check("mti_mtval", excp_mtval, 32'd0);
    @(negedge clk);
    check_strobes("mti_c3_strobes", 6'b000001);
    check("mti_flush_pc", excp_flush_pc, 32'h81C);
    @(negedge clk);

    // globally disabled: no accept
    csr_mstatus_mie = 1'b0; irq_pend = 3'b010;
    fire("mti_off", 1'b0);
    @(negedge clk);
    check("mti_off_c1_stall", {31'd0, trap_stall}, 32'd0);
    @(negedge clk);
    check_strobes("mti_off_c2_strobes", 6'b000000);

    // ---------------- MEI beats MTI and ecall ----------------
    csr_mtvec = 32'h800; csr_mie = 3'b111; csr_mstatus_mie = 1'b1;
    excp_pc = 32'h300; excp_instr = 32'h0000_0073;
    irq_pend = 3'b110; excp_ecall = 1'b1;
    fire("mei", 1'b1);
    repeat (2) @(negedge clk);
    check_strobes("mei_c2_strobes", 6'b111100);
    check("mei_mcause", excp_mcause, 32'h8000_000B);
    check("mei_mepc", excp_mepc, 32'h300);
    check("mei_mtval", excp_mtval, 32'd0);
    @(negedge clk);
    check("mei_flush_pc", excp_flush_pc, 32'h800);
    @(negedge clk);
    csr_mstatus_mie = 1'b0; csr_mie = 3'b000;

    // ---------------- mret with late drain ----------------
    csr_mepc = 32'h2000; pipe_drained = 1'b0; excp_mret = 1'b1;
    fire("mret", 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("mret_drain%0d_stall", i), {31'd0, trap_stall}, 32'd1);
      check_strobes($sformatf("mret_drain%0d_strobes", i), 6'b000000);
    end
    pipe_drained = 1'b1;
    @(negedge clk);
    check_strobes("mret_strobes", 6'b000011);
    check("mret_flush_pc", excp_flush_pc, 32'h2000);
    check("mret_mcause_kept", excp_mcause, 32'h8000_000B);
    @(negedge clk);
    check("mret_done_stall", {31'd0, trap_stall}, 32'd0);
    check_strobes("mret_done_strobes", 6'b000000);

    // ---------------- mret loses to load misalign ----------------
    excp_pc = 32'h404; excp_badaddr = 32'h1233; csr_mepc = 32'h3000;
    excp_mret = 1'b1; excp_ld_misalign = 1'b1;
    fire("ldm", 1'b1);
    @(negedge clk);
    check_strobes("ldm_c1_strobes", 6'b000000);
    @(negedge clk);
    check_strobes("ldm_c2_strobes", 6'b111100);
    check("ldm_mcause", excp_mcause, 32'd4);
    check("ldm_mtval", excp_mtval, 32'h1233);
    @(negedge clk);
    check_strobes("ldm_c3_strobes", 6'b000001);
    check("ldm_flush_pc", excp_flush_pc, 32'h800);
    @(negedge clk);

    // ---------------- reset while draining ----------------
    pipe_drained = 1'b0; excp_pc = 32'h60; excp_ebreak = 1'b1;
    fire("rstd", 1'b1);
    @(negedge clk);
    check("rstd_c1_stall", {31'd0, trap_stall}, 32'd1);
    reset = 1'b1;
    #1;
    check("rstd_stall", {31'd0, trap_stall}, 32'd0);
    check("rstd_mepc", excp_mepc, 32'd0);
    check("rstd_mcause", excp_mcause, 32'd0);
    check("rstd_mtval", excp_mtval, 32'd0);
    check("rstd_flush_pc", excp_flush_pc, 32'd0);
    @(negedge clk);
    reset = 1'b0; pipe_drained = 1'b1;
    @(negedge clk);
    check("rstd_post_stall", {31'd0, trap_stall}, 32'd0);
    check_strobes("rstd_post_strobes1", 6'b000000);
    @(negedge clk);
    check_strobes("rstd_post_strobes2", 6'b000000);

    // fresh ebreak after reset
    excp_pc = 32'h40; excp_ebreak = 1'b1;
    fire("ebk", 1'b1);
    repeat (2) @(negedge clk);
    check_strobes("ebk_c2_strobes", 6'b111100);
    check("ebk_mcause", excp_mcause, 32'd3);
    check("ebk_mtval", excp_mtval, 32'h40);
    check("ebk_mepc", excp_mepc, 32'h40);
    @(negedge clk);
    check("ebk_flush_pc", excp_flush_pc, 32'h800);
    check_strobes("ebk_c3_strobes", 6'b000001);
    @(negedge clk);
    check("ebk_c4_stall", {31'd0, trap_stall}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
